// File: rtl/hazard_pkg.sv
// Shared constants, latency clamp and counter-pair type for the hazard scoreboard.
package hazard_pkg;

  localparam int NREGS_DEF   = 16;
  localparam int MAX_LAT_DEF = 4;
  localparam int WB_DIST_DEF = 2;
  localparam int CNT_W_DEF   = $clog2(MAX_LAT_DEF + WB_DIST_DEF + 1);

  // Counter pair at the default geometry: cycles to forwardable, cycles to RF write.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] rdy_cnt;
    logic [CNT_W_DEF-1:0] wb_cnt;
  } cnt_pair_t;

  function automatic int clamp_lat(input int lat, input int max_lat);
    if (lat < 1) return 1;
    if (lat > max_lat) return max_lat;
    return lat;
  endfunction

endpackage

// File: rtl/hazard_reg_slot.sv
// One tracked register: forwardable and writeback countdowns with issue load and freeze hold.
module hazard_reg_slot
  import hazard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             load,
  input  logic [CNT_W-1:0] load_rdy,
  input  logic [CNT_W-1:0] load_wb,
  output logic [CNT_W-1:0] rdy_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_cnt <= '0;
      wb_cnt  <= '0;
    end else if (!freeze) begin
      if (load) begin
        rdy_cnt <= load_rdy;
        wb_cnt  <= load_wb;
      end else begin
        if (rdy_cnt != '0) rdy_cnt <= rdy_cnt - CNT_W'(1);
        if (wb_cnt != '0)  wb_cnt  <= wb_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard for in-flight register writes: ID stall, bypass select and pending mask.
// Optional HAZ_PERF_CNT_EN adds a saturating stall_cycles counter output.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS   = NREGS_DEF,
  parameter int REG_W   = $clog2(NREGS),
  parameter int MAX_LAT = MAX_LAT_DEF,
  parameter int WB_DIST = WB_DIST_DEF,
  parameter int CNT_W   = $clog2(MAX_LAT + WB_DIST + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rs1,
  input  logic             issue_rs1_used,
  input  logic [REG_W-1:0] issue_rs2,
  input  logic             issue_rs2_used,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_rd_en,
  input  logic [CNT_W-1:0] issue_lat,
  input  logic             flush,
  input  logic             freeze,
  output logic             stall,
  output logic             rs1_fwd,
  output logic [CNT_W-1:0] rs1_fwd_age,
  output logic             rs2_fwd,
  output logic [CNT_W-1:0] rs2_fwd_age,
  output logic [NREGS-1:0] pending_mask
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  logic [CNT_W-1:0] rdy_cnt [NREGS];
  logic [CNT_W-1:0] wb_cnt  [NREGS];
  logic [CNT_W-1:0] lat_c;
  logic [CNT_W-1:0] load_rdy;
  logic [CNT_W-1:0] load_wb;
  logic             raw1, raw2, waw, accept;

  assign lat_c    = CNT_W'(clamp_lat(int'(issue_lat), MAX_LAT));
  assign load_rdy = lat_c - CNT_W'(1);
  assign load_wb  = lat_c - CNT_W'(1) + CNT_W'(WB_DIST);

  // r0 is hardwired: never pending, never a hazard.
  assign rdy_cnt[0] = '0;
  assign wb_cnt[0]  = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_slot
    hazard_reg_slot #(.CNT_W(CNT_W)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .freeze   (freeze),
      .load     (accept && issue_rd_en && (issue_rd == REG_W'(r))),
      .load_rdy (load_rdy),
      .load_wb  (load_wb),
      .rdy_cnt  (rdy_cnt[r]),
      .wb_cnt   (wb_cnt[r])
    );
  end

  assign raw1   = issue_rs1_used && (issue_rs1 != '0) && (rdy_cnt[issue_rs1] != '0);
  assign raw2   = issue_rs2_used && (issue_rs2 != '0) && (rdy_cnt[issue_rs2] != '0);
  // A shorter-latency write may not overtake an older one to the same register.
  assign waw    = issue_rd_en && (issue_rd != '0) && (rdy_cnt[issue_rd] > load_rdy);
  assign stall  = issue_valid && (raw1 || raw2 || waw);
  assign accept = issue_valid && !stall && !flush && !freeze;

  assign rs1_fwd = issue_valid && issue_rs1_used && (issue_rs1 != '0) &&
                   (rdy_cnt[issue_rs1] == '0) && (wb_cnt[issue_rs1] != '0);
  assign rs2_fwd = issue_valid && issue_rs2_used && (issue_rs2 != '0) &&
                   (rdy_cnt[issue_rs2] == '0) && (wb_cnt[issue_rs2] != '0);
  assign rs1_fwd_age = rs1_fwd ? wb_cnt[issue_rs1] : '0;
  assign rs2_fwd_age = rs2_fwd ? wb_cnt[issue_rs2] : '0;

  always_comb begin
    pending_mask = '0;
    for (int r = 1; r < NREGS; r++) pending_mask[r] = (wb_cnt[r] != '0);
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles <= '0;
    else if (!freeze && stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table plus freeze and async-reset sequences.
module tb_hazard_scoreboard;

  localparam int NREGS = 16;
  localparam int REG_W = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_valid;
  logic [REG_W-1:0] issue_rs1, issue_rs2, issue_rd;
  logic             issue_rs1_used, issue_rs2_used, issue_rd_en;
  logic [CNT_W-1:0] issue_lat;
  logic             flush, freeze;
  logic             stall, rs1_fwd, rs2_fwd;
  logic [CNT_W-1:0] rs1_fwd_age, rs2_fwd_age;
  logic [NREGS-1:0] pending_mask;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]      stall_cycles;
`endif

  int checks = 0;
  int failures = 0;

  hazard_scoreboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_rs1      (issue_rs1),
    .issue_rs1_used (issue_rs1_used),
    .issue_rs2      (issue_rs2),
    .issue_rs2_used (issue_rs2_used),
    .issue_rd       (issue_rd),
    .issue_rd_en    (issue_rd_en),
    .issue_lat      (issue_lat),
    .flush          (flush),
    .freeze         (freeze),
    .stall          (stall),
    .rs1_fwd        (rs1_fwd),
    .rs1_fwd_age    (rs1_fwd_age),
    .rs2_fwd        (rs2_fwd),
    .rs2_fwd_age    (rs2_fwd_age),
    .pending_mask   (pending_mask)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             valid;
    logic [REG_W-1:0] rs1;
    logic             u1;
    logic [REG_W-1:0] rs2;
    logic             u2;
    logic [REG_W-1:0] rd;
    logic             en;
    logic [CNT_W-1:0] lat;
    logic             fl;
    logic             fz;
    logic             e_stall;
    logic             e_f1;
    logic [CNT_W-1:0] e_a1;
    logic             e_f2;
    logic [CNT_W-1:0] e_a2;
    logic [NREGS-1:0] e_mask;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int valid, int rs1, int u1, int rs2, int u2, int rd, int en,
                              int lat, int fl, int fz, int e_stall, int e_f1, int e_a1,
                              int e_f2, int e_a2, int e_mask);
    vec_t v;
    v.valid = valid[0]; v.rs1 = REG_W'(rs1); v.u1 = u1[0];
    v.rs2 = REG_W'(rs2); v.u2 = u2[0]; v.rd = REG_W'(rd); v.en = en[0];
    v.lat = CNT_W'(lat); v.fl = fl[0]; v.fz = fz[0];
    v.e_stall = e_stall[0]; v.e_f1 = e_f1[0]; v.e_a1 = CNT_W'(e_a1);
    v.e_f2 = e_f2[0]; v.e_a2 = CNT_W'(e_a2); v.e_mask = NREGS'(e_mask);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    issue_valid = v.valid; issue_rs1 = v.rs1; issue_rs1_used = v.u1;
    issue_rs2 = v.rs2; issue_rs2_used = v.u2; issue_rd = v.rd;
    issue_rd_en = v.en; issue_lat = v.lat; flush = v.fl; freeze = v.fz;
  endtask

  task automatic compare(input vec_t v, input string name);
    checks++;
    if (stall !== v.e_stall || rs1_fwd !== v.e_f1 || rs1_fwd_age !== v.e_a1 ||
        rs2_fwd !== v.e_f2 || rs2_fwd_age !== v.e_a2 || pending_mask !== v.e_mask) begin
      failures++;
      $display("FAIL %s: stall/f1/a1/f2/a2/mask got %b/%b/%0d/%b/%0d/%h want %b/%b/%0d/%b/%0d/%h",
               name, stall, rs1_fwd, rs1_fwd_age, rs2_fwd, rs2_fwd_age, pending_mask,
               v.e_stall, v.e_f1, v.e_a1, v.e_f2, v.e_a2, v.e_mask);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    drive(v);
    #1;
    compare(v, name);
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic check_perf(input logic [31:0] exp, input string name);
    checks++;
    if (stall_cycles !== exp) begin
      failures++;
      $display("FAIL %s: stall_cycles got %0d want %0d", name, stall_cycles, exp);
    end
  endtask
`endif

  initial begin
    // valid rs1 u1 rs2 u2 rd en lat fl fz | stall f1 a1 f2 a2 mask
    // RAW back-to-back, L=1
    vecs.push_back(mk(1, 0,0, 0,0, 5,1, 1, 0,0,  0, 0,0, 0,0, 'h0000));
    vecs.push_back(mk(1, 5,1, 0,0, 0,0, 1, 0,0,  0, 1,2, 0,0, 'h0020));
    vecs.push_back(mk(1, 5,1, 0,0, 0,0, 1, 0,0,  0, 1,1, 0,0, 'h0020));
    vecs.push_back(mk(1, 5,1, 0,0, 0,0, 1, 0,0,  0, 0,0, 0,0, 'h0000));
    // multi-cycle producer L=3, consumer on rs2
    vecs.push_back(mk(1, 0,0, 0,0, 7,1, 3, 0,0,  0, 0,0, 0,0, 'h0000));
    vecs.push_back(mk(1, 0,0, 7,1, 0,0, 1, 0,0,  1, 0,0, 0,0, 'h0080));
    vecs.push_back(mk(1, 0,0, 7,1, 0,0, 1, 0,0,  1, 0,0, 0,0, 'h0080));
    vecs.push_back(mk(1, 0,0, 7,1, 0,0, 1, 0,0,  0, 0,0, 1,2, 'h0080));
    vecs.push_back(mk(0, 0,0, 7,1, 0,0, 1, 0,0,  0, 0,0, 0,0, 'h0080));
    // flush drops the write; rd=0 never tracked
    vecs.push_back(mk(1, 0,0, 0,0, 9,1, 1, 1,0,  0, 0,0, 0,0, 'h0000));
    vecs.push_back(mk(1, 0,0, 0,0, 0,1, 2, 0,0,  0, 0,0, 0,0, 'h0000));
    vecs.push_back(mk(1, 9,1, 0,1, 0,0, 1, 0,0,  0, 0,0, 0,0, 'h0000));
    // WAW: L=4 then L=1 to same rd
    vecs.push_back(mk(1, 0,0, 0,0, 4,1, 4, 0,0,  0, 0,0, 0,0, 'h0000));
    vecs.push_back(mk(1, 0,0, 0,0, 4,1, 1, 0,0,  1, 0,0, 0,0, 'h0010));
    vecs.push_back(mk(1, 0,0, 0,0, 4,1, 1, 0,0,  1, 0,0, 0,0, 'h0010));
    vecs.push_back(mk(1, 0,0, 0,0, 4,1, 1, 0,0,  1, 0,0, 0,0, 'h0010));
    vecs.push_back(mk(1, 0,0, 0,0, 4,1, 1, 0,0,  0, 0,0, 0,0, 'h0010));
    vecs.push_back(mk(1, 4,1, 4,1, 0,0, 1, 0,0,  0, 1,2, 1,2, 'h0010));
    vecs.push_back(mk(0, 0,0, 0,0, 0,0, 1, 0,0,  0, 0,0, 0,0, 'h0010));
    vecs.push_back(mk(0, 0,0, 0,0, 0,0, 1, 0,0,  0, 0,0, 0,0, 'h0000));
    // WAW boundary: rdy == L-1 is allowed and reloads
    vecs.push_back(mk(1, 0,0, 0,0, 2,1, 3, 0,0,  0, 0,0, 0,0, 'h0000));
    vecs.push_back(mk(1, 0,0, 0,0, 2,1, 3, 0,0,  0, 0,0, 0,0, 'h0004));
    vecs.push_back(mk(1, 2,1, 0,0, 0,0, 1, 0,0,  1, 0,0, 0,0, 'h0004));
    vecs.push_back(mk(1, 2,1, 0,0, 0,0, 1, 1,0,  1, 0,0, 0,0, 'h0004));
    vecs.push_back(mk(1, 2,1, 0,0, 0,0, 1, 0,0,  0, 1,2, 0,0, 'h0004));
    vecs.push_back(mk(0, 0,0, 0,0, 0,0, 1, 0,0,  0, 0,0, 0,0, 'h0004));
    // latency clamp: 0 -> 1, 7 -> 4
    vecs.push_back(mk(1, 0,0, 0,0, 6,1, 0, 0,0,  0, 0,0, 0,0, 'h0000));
    vecs.push_back(mk(1, 6,1, 0,0, 0,0, 1, 0,0,  0, 1,2, 0,0, 'h0040));
    vecs.push_back(mk(1, 6,1, 0,0, 8,1, 7, 0,0,  0, 1,1, 0,0, 'h0040));
    vecs.push_back(mk(1, 0,0, 8,1, 0,0, 1, 0,0,  1, 0,0, 0,0, 'h0100));
    vecs.push_back(mk(0, 0,0, 0,0, 0,0, 1, 0,0,  0, 0,0, 0,0, 'h0100));
    vecs.push_back(mk(0, 0,0, 0,0, 0,0, 1, 0,0,  0, 0,0, 0,0, 'h0100));
    vecs.push_back(mk(0, 0,0, 0,0, 0,0, 1, 0,0,  0, 0,0, 0,0, 'h0100));
    vecs.push_back(mk(0, 0,0, 0,0, 0,0, 1, 0,0,  0, 0,0, 0,0, 'h0100));
    vecs.push_back(mk(0, 0,0, 0,0, 0,0, 1, 0,0,  0, 0,0, 0,0, 'h0000));

    rst_n = 1'b0;
    drive(mk(0, 0,0, 0,0, 0,0, 1, 0,0,  0, 0,0, 0,0, 0));
    #3;
    compare(mk(0, 0,0, 0,0, 0,0, 1, 0,0,  0, 0,0, 0,0, 0), "reset");
`ifdef HAZ_PERF_CNT_EN
    check_perf(32'd0, "reset_perf");
`endif
    #4 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // freeze holds r3's counters; freeze also blocks recording rd=10
    apply(mk(1, 0,0, 0,0, 3,1, 3, 0,0,  0, 0,0, 0,0, 'h0000), "frz_issue");
    for (int i = 0; i < 3; i++)
      apply(mk(1, 3,1, 0,0, 0,0, 1, 0,1,  1, 0,0, 0,0, 'h0008), $sformatf("frz_hold%0d", i));
    apply(mk(1, 0,0, 0,0, 10,1, 1, 0,1,  0, 0,0, 0,0, 'h0008), "frz_norec");
    apply(mk(1, 3,1, 0,0, 0,0, 1, 0,0,  1, 0,0, 0,0, 'h0008), "frz_resume0");
    apply(mk(1, 3,1, 0,0, 0,0, 1, 0,0,  1, 0,0, 0,0, 'h0008), "frz_resume1");
    apply(mk(1, 3,1, 0,0, 0,0, 1, 0,0,  0, 1,2, 0,0, 'h0008), "frz_fwd");
`ifdef HAZ_PERF_CNT_EN
    check_perf(32'd10, "perf_count");
`endif

    // async reset with r2, r6, r11 pending
    apply(mk(1, 0,0, 0,0, 2,1, 4, 0,0,  0, 0,0, 0,0, 'h0008), "rst_a");
    apply(mk(1, 0,0, 0,0, 6,1, 4, 0,0,  0, 0,0, 0,0, 'h0004), "rst_b");
    apply(mk(1, 0,0, 0,0, 11,1, 4, 0,0, 0, 0,0, 0,0, 'h0044), "rst_c");
    apply(mk(1, 2,1, 11,1, 0,0, 1, 0,0, 1, 0,0, 0,0, 'h0844), "rst_pre");
    #1 rst_n = 1'b0;
    #1;
    compare(mk(1, 2,1, 11,1, 0,0, 1, 0,0, 0, 0,0, 0,0, 'h0000), "rst_async");
`ifdef HAZ_PERF_CNT_EN
    check_perf(32'd0, "rst_perf");
`endif
    #1 rst_n = 1'b1;
    drive(mk(0, 0,0, 0,0, 0,0, 1, 0,0,  0, 0,0, 0,0, 0));
    apply(mk(1, 11,1, 6,1, 0,0, 1, 0,0, 0, 0,0, 0,0, 'h0000), "rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the combinational hazard control unit. It tracks in-flight register writes with per-register countdown counters, so it supports variable-latency (multi-cycle) execute units, configurable register count and configurable pipeline distance to writeback. Each cycle it produces the ID-stage stall, per-source forwarding enables and forwarding age, and it honours branch flush and a global pipeline freeze. It sits beside the register file and is driven by ID (issue), EX (branch resolution) and the memory system (freeze).

Parameters:
NREGS, 16, architectural register count. Register 0 is never tracked and never causes a hazard.
REG_W, $clog2(NREGS), register index width.
MAX_LAT, 4, maximum execute latency in cycles. Range 1..MAX_LAT.
WB_DIST, 2, stages between execute result and register-file write (MEM, WB).
CNT_W, $clog2(MAX_LAT+WB_DIST+1), counter width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  instruction present in ID
issue_rs1  in  REG_W  source 1 index
issue_rs1_used  in  1  source 1 read by instruction
issue_rs2  in  REG_W  source 2 index
issue_rs2_used  in  1  source 2 read by instruction
issue_rd  in  REG_W  destination index
issue_rd_en  in  1  instruction writes issue_rd
issue_lat  in  CNT_W  execute latency; 0 treated as 1, values above MAX_LAT clamped to MAX_LAT
flush  in  1  branch taken in EX; kills the current ID instruction
freeze  in  1  whole pipeline held (e.g. dcache busy)
stall  out  1  ID must hold; insert bubble into EX
rs1_fwd  out  1  take rs1 from the bypass network
rs1_fwd_age  out  CNT_W  cycles until the producer writes the RF; selects the bypass stage
rs2_fwd  out  1  as rs1_fwd, for source 2
rs2_fwd_age  out  CNT_W  as rs1_fwd_age, for source 2
pending_mask  out  NREGS  bit r set while register r has an uncommitted write

Behaviour:
- State per register r (r ≥ 1): rdy_cnt[r] = cycles until the result is forwardable; wb_cnt[r] = cycles until the RF write completes. Both are CNT_W wide.
- Reset (rst_n = 0, asynchronous): all counters go to 0.
  - Consequently stall = 0, rs*_fwd = 0, rs*_fwd_age = 0 and pending_mask = 0 immediately, including when reset is asserted mid-operation.
- Hazard terms (combinational from state and inputs):
  - raw1 = issue_rs1_used and rs1 ≠ 0 and rdy_cnt[rs1] > 0. raw2 is analogous for rs2.
  - waw = issue_rd_en and rd ≠ 0 and rdy_cnt[rd] > L−1, where L is the clamped latency. This prevents out-of-order completion.
  - stall = issue_valid and (raw1 or raw2 or waw).
- Forwarding:
  - rsN_fwd = issue_valid and used and rs ≠ 0 and rdy_cnt = 0 and wb_cnt > 0.
  - rsN_fwd_age = wb_cnt[rs] when rsN_fwd is 1, else 0.
- Accept condition: accept = issue_valid and not stall and not flush and not freeze.
- Each clock edge:
  - If freeze = 1: all counters hold and nothing is recorded.
  - Otherwise, every nonzero counter decrements by 1, saturating at 0.
  - If accept, issue_rd_en and rd ≠ 0: rdy_cnt[rd] ← L−1 and wb_cnt[rd] ← L−1+WB_DIST. The issue load overrides the decrement for that register in the same cycle.
- Latency: one-cycle ALU producer (L = 1) to its immediate consumer means no stall, forwarded with age = WB_DIST.
- pending_mask[r] = (wb_cnt[r] ≠ 0). Bit 0 is always 0.
- flush and stall together: the instruction is dropped (flush wins) and no entry is recorded.
- Consumer of a register whose wb_cnt = 0 reads the RF: fwd = 0 and no stall.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds output stall_cycles (32 bits). It increments each non-freeze cycle in which stall = 1, saturates at 0xFFFFFFFF, and resets to 0.
- Undefined: the port and the counter are absent; all other behaviour is unchanged.

Decomposition:
- Package hazard_pkg holds:
  - the default parameter constants;
  - a function clamp_lat(lat) returning 1..MAX_LAT;
  - a typedef for the per-register counter pair {rdy_cnt, wb_cnt}.
- One natural sub-module, hazard_reg_slot: one register's counter pair with its load, decrement and freeze logic, instantiated NREGS−1 times via generate.
- The top module holds the source and destination lookup muxes, the stall and forward logic, and the optional performance counter.

Test Plan:
1. RAW back-to-back, L = 1:
   - Stimulus: issue rd = 5; next cycle issue rs1 = 5 used.
   - Required: stall = 0, rs1_fwd = 1, rs1_fwd_age = 2. The following cycle with rs1 = 5: age = 1. The cycle after: fwd = 0 and pending_mask[5] = 0.
2. Multi-cycle producer, L = 3:
   - Stimulus: issue rd = 7; dependent instruction on rs2 = 7 held in ID.
   - Required: stall = 1 for 2 cycles, then stall = 0 with rs2_fwd = 1 and age = 2.
3. Freeze:
   - Stimulus: issue rd = 3, L = 3; assert freeze for 4 cycles.
   - Required: rdy_cnt[3] and wb_cnt[3] unchanged throughout, pending_mask[3] = 1. After freeze drops, counting resumes from the held values.
4. Flush:
   - Stimulus: issue rd = 9 with flush = 1.
   - Required: pending_mask[9] remains 0. Issuing to rd = 0 also leaves the mask all zero.
5. WAW:
   - Stimulus: rd = 4 issued with L = 4; next cycle issue rd = 4 with L = 1.
   - Required: stall = 1 for 3 cycles, then accepted, pending_mask[4] = 1.
6. Asynchronous reset mid-operation:
   - Stimulus: with r2, r6 and r11 pending, pulse rst_n low between clock edges.
   - Required: pending_mask = 0 and stall = 0 immediately. With HAZ_PERF_CNT_EN defined, stall_cycles = 0.
